id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and operand-select stage directly upstream of the 48-bit ALU.
//  Latches decoded operands, sign-/zero-extends immediates and decodes opcode/funct into the 4-bit ALU control.
//  Presents registered operand A/B and control to the ALU, with optional EX/MEM and MEM/WB forwarding.
//  Valid/ready handshake on both sides; supports stall (back-pressure) and flush.
// PARAMETERS
//  DATA_W  48  operand/result width; matches ALU a/b/result
//  IMM_W   16  raw immediate width; extended to DATA_W
//  REG_AW  5   register address width
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       asynchronous reset, active-high
//  flush        in   1       sync kill of the held entry and the incoming entry (branch redirect)
//  in_valid     in   1       decode stage has an instruction
//  in_ready     out  1       stage can accept this cycle
//  in_opcode    in   6       instruction opcode
//  in_funct     in   6       R-type funct
//  in_rs_addr   in   REG_AW  source reg A address
//  in_rt_addr   in   REG_AW  source reg B address
//  in_rd_addr   in   REG_AW  destination (rd for R-type, rt for I-type; decode selects it)
//  in_rs_data   in   DATA_W  register-file read A
//  in_rt_data   in   DATA_W  register-file read B
//  in_imm       in   IMM_W   raw immediate
//  exm_wen      in   1       EX/MEM instruction writes a register
//  exm_rd       in   REG_AW  EX/MEM destination
//  exm_data     in   DATA_W  EX/MEM ALU result
//  mwb_wen      in   1       MEM/WB instruction writes a register
//  mwb_rd       in   REG_AW  MEM/WB destination
//  mwb_data     in   DATA_W  MEM/WB writeback value
//  out_valid    out  1       ALU operands valid
//  out_ready    in   1       downstream accepts
//  alu_a        out  DATA_W  ALU operand a
//  alu_b        out  DATA_W  ALU operand b
//  alu_control  out  4       ALU control code
//  out_rd_addr  out  REG_AW  destination for writeback
//  out_reg_wen  out  1       instruction writes a register
//  out_mem_rd   out  1       load
//  out_mem_wr   out  1       store; out_store_data carries the value
//  out_store_data out DATA_W  forwarded rt value for stores
//  out_illegal  out  1       unknown opcode/funct; reg_wen/mem_rd/mem_wr forced 0
// BEHAVIOUR
//  Reset: out_valid=0, every registered field=0; alu_a/alu_b/out_store_data=0 (no forwarding while !out_valid).
//  Handshake: in_ready = !out_valid | out_ready. Capture when in_valid & in_ready; latency 1 cycle.
//  Hold: out_valid & !out_ready -> all outputs stable, no capture.
//  Transfer: out_valid & out_ready & !in_valid -> out_valid=0 next cycle.
//  Flush: flush=1 -> out_valid=0 next cycle; a simultaneous input is accepted (in_ready unaffected) and dropped.
//  Flush wins over capture and hold.
//  Decode (R-type opcode 0x00): funct 0x24 AND=0x0, 0x25 OR=0x1, 0x20 ADD=0x2, 0x22 SUB=0x6, 0x2A SLT=0x7, 0x27 NOR=0xC.
//  I-type: 0x08 addi=0x2, 0x0C andi=0x0, 0x0D ori=0x1, 0x0A slti=0x7, 0x23 lw=0x2 (mem_rd), 0x2B sw=0x2 (mem_wr),
//    0x04 beq=0x6 (no reg_wen). All others: illegal=1, control=0x2.
//  Operand B: rt data for R-type and beq; immediate for all other I-types.
//  Immediate: zero-extended for andi/ori, sign-extended to DATA_W otherwise. Extension is applied at capture.
//  Writes to r0: out_reg_wen=0 whenever out_rd_addr==0.
// CONFIGURATION
//  ID_EX_FWD_EN defined: forwarding muxes sit on the registered rs/rt values (combinational, EX side).
//    Priority: exm (exm_wen & exm_rd==addr & addr!=0) > mwb (same test) > latched regfile data.
//    Applies to alu_a, to alu_b when B=rt, and to out_store_data.
//  ID_EX_FWD_EN undefined: alu_a/alu_b come straight from the registers; exm_*/mwb_* are ignored.
//    Hazards are the decode stage's responsibility.
// STRUCTURE
//  alu_pkg: ALU code localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR), opcode/funct constants, DATA_W.
//  Sub-module alu_ctrl_dec: combinational opcode/funct -> {control, b_is_imm, zext, reg_wen, mem_rd, mem_wr, illegal}.
//  Top holds the pipeline register, extension logic and forwarding muxes.
// TESTING
//  1. R-type SUB, rs_data=10, rt_data=3, out_ready=1 -> next cycle out_valid=1, alu_a=10, alu_b=3, control=0x6.
//  2. addi with imm=0xFFFF -> alu_b=48'hFFFF_FFFF_FFFF. ori with imm=0xFFFF -> alu_b=48'h0000_0000_FFFF, control=0x1.
//  3. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen; release -> next instruction captured.
//  4. flush concurrent with in_valid and a held entry -> out_valid=0 next cycle; no transfer of either.
//  5. FWD_EN: rs=5, exm_rd=5 with exm_data=7, mwb_rd=5 with mwb_data=9 -> alu_a=7; rs=0 with exm_rd=0 -> alu_a=regfile data.
//  6. opcode 0x3F -> out_illegal=1, reg_wen=0; rst asserted mid-hold -> out_valid=0 immediately, async.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU control codes, opcode/funct constants and the default datapath width
// for the ID/EX stage and its decoder.
package alu_pkg;

  localparam int unsigned DATA_W = 48;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;
  localparam logic [3:0] ALU_NOR = 4'hC;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef struct packed {
    logic [3:0] control;
    logic       b_is_imm;
    logic       zext;
    logic       reg_wen;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational opcode/funct decoder producing ALU control and operand/side-effect flags.
module alu_ctrl_dec (
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output alu_pkg::dec_t dec
);
  import alu_pkg::*;

  always_comb begin
    dec          = '0;
    dec.control  = ALU_ADD;
    dec.b_is_imm = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        dec.b_is_imm = 1'b0;
        dec.reg_wen  = 1'b1;
        case (funct)
          FN_AND:  dec.control = ALU_AND;
          FN_OR:   dec.control = ALU_OR;
          FN_ADD:  dec.control = ALU_ADD;
          FN_SUB:  dec.control = ALU_SUB;
          FN_SLT:  dec.control = ALU_SLT;
          FN_NOR:  dec.control = ALU_NOR;
          default: begin
            dec.reg_wen = 1'b0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: dec.reg_wen = 1'b1;
      OP_ANDI: begin dec.reg_wen = 1'b1; dec.zext = 1'b1; dec.control = ALU_AND; end
      OP_ORI:  begin dec.reg_wen = 1'b1; dec.zext = 1'b1; dec.control = ALU_OR;  end
      OP_SLTI: begin dec.reg_wen = 1'b1; dec.control = ALU_SLT; end
      OP_LW:   begin dec.reg_wen = 1'b1; dec.mem_rd = 1'b1; end
      OP_SW:   dec.mem_wr = 1'b1;
      OP_BEQ:  begin dec.b_is_imm = 1'b0; dec.control = ALU_SUB; end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with immediate extension and ALU control decode.
// Optional EX/MEM and MEM/WB operand forwarding enabled by defining ID_EX_FWD_EN.
module id_ex_stage #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_funct,
  input  logic [REG_AW-1:0] in_rs_addr,
  input  logic [REG_AW-1:0] in_rt_addr,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              exm_wen,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_wen,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_control,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_reg_wen,
  output logic              out_mem_rd,
  output logic              out_mem_wr,
  output logic [DATA_W-1:0] out_store_data,
  output logic              out_illegal
);
  import alu_pkg::*;

  dec_t              dec;
  logic [DATA_W-1:0] imm_ext;

  logic              valid_q;
  logic [DATA_W-1:0] rs_q, rt_q, imm_q;
  logic [REG_AW-1:0] rs_addr_q, rt_addr_q, rd_q;
  logic [3:0]        control_q;
  logic              b_is_imm_q, reg_wen_q, mem_rd_q, mem_wr_q, illegal_q;
  logic [DATA_W-1:0] fwd_a, fwd_b;

  alu_ctrl_dec u_dec (
    .opcode (in_opcode),
    .funct  (in_funct),
    .dec    (dec)
  );

  always_comb begin
    if (dec.zext) imm_ext = {{(DATA_W-IMM_W){1'b0}}, in_imm};
    else          imm_ext = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};
  end

  assign in_ready = !valid_q || out_ready;

  // Flush kills both the held entry and a same-cycle capture; the input is still consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rd_q       <= '0;
      control_q  <= '0;
      b_is_imm_q <= 1'b0;
      reg_wen_q  <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (flush)         valid_q <= 1'b0;
      else if (in_ready) valid_q <= in_valid;
      if (in_valid && in_ready && !flush) begin
        rs_q       <= in_rs_data;
        rt_q       <= in_rt_data;
        imm_q      <= imm_ext;
        rs_addr_q  <= in_rs_addr;
        rt_addr_q  <= in_rt_addr;
        rd_q       <= in_rd_addr;
        control_q  <= dec.control;
        b_is_imm_q <= dec.b_is_imm;
        reg_wen_q  <= dec.reg_wen;
        mem_rd_q   <= dec.mem_rd;
        mem_wr_q   <= dec.mem_wr;
        illegal_q  <= dec.illegal;
      end
    end
  end

`ifdef ID_EX_FWD_EN
  always_comb begin
    fwd_a = rs_q;
    fwd_b = rt_q;
    if (valid_q) begin
      if (exm_wen && exm_rd == rs_addr_q && rs_addr_q != '0)      fwd_a = exm_data;
      else if (mwb_wen && mwb_rd == rs_addr_q && rs_addr_q != '0) fwd_a = mwb_data;
      if (exm_wen && exm_rd == rt_addr_q && rt_addr_q != '0)      fwd_b = exm_data;
      else if (mwb_wen && mwb_rd == rt_addr_q && rt_addr_q != '0) fwd_b = mwb_data;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data,
                        rs_addr_q, rt_addr_q};
  assign fwd_a = rs_q;
  assign fwd_b = rt_q;
`endif

  assign out_valid      = valid_q;
  assign alu_a          = fwd_a;
  assign alu_b          = b_is_imm_q ? imm_q : fwd_b;
  assign out_store_data = fwd_b;
  assign alu_control    = control_q;
  assign out_rd_addr    = rd_q;
  assign out_reg_wen    = reg_wen_q && (rd_q != '0);
  assign out_mem_rd     = mem_rd_q;
  assign out_mem_wr     = mem_wr_q;
  assign out_illegal    = illegal_q;

endmodule
